// File: rtl/output_spike_collector_pkg.sv
// Shared configuration, entry layout and helpers for the output spike collector.
// The OUTPUT_SPIKE_COUNT_EN option itself lives in the top module.
package ranc_output_pkg;

   function automatic int clog2_w(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

   localparam int NUM_OUTPUTS    = 256;
   localparam int NUM_TICKS      = 16;
   localparam int FIFO_DEPTH     = 64;
   localparam int DROP_CNT_WIDTH = 16;

   localparam int IDX_W   = clog2_w(NUM_OUTPUTS);
   localparam int TS_W    = clog2_w(NUM_TICKS);
   localparam int PTR_W   = clog2_w(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENTRY_W = TS_W + IDX_W;

   localparam logic [DROP_CNT_WIDTH-1:0] DROP_CNT_MAX = '1;

   typedef struct packed {
      logic [TS_W-1:0]  tick_stamp;
      logic [IDX_W-1:0] index;
   } entry_t;

endpackage

// File: rtl/output_spike_collector_spike_fifo.sv
// Show-ahead FIFO with a registered occupancy counter; a push is still taken
// when full if the head is being popped in the same cycle.
module spike_fifo
   import ranc_output_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               rd_ready,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               rd_valid,
   output logic               push_ok,
   output logic [LVL_W-1:0]   level
);

   logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic               full, empty, pop;

   assign empty    = (level_q == '0);
   assign full     = (level_q == LVL_W'(FIFO_DEPTH));
   assign rd_valid = !empty;
   assign pop      = rd_valid && rd_ready;
   assign push_ok  = push && (!full || pop);
   // Gated so the output reads zero whenever nothing valid is held.
   assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign level    = level_q;

   // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; validity is tracked by level_q alone.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/output_spike_collector.sv
// Tags output-bus spikes with the tick stamp, buffers them and tracks drops.
// Define OUTPUT_SPIKE_COUNT_EN to add the per-tick accepted-spike counter.
module output_spike_collector
   import ranc_output_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IDX_W-1:0]          packet_in,
   input  logic                      packet_in_valid,
   input  logic                      tick,
   input  logic                      clear_status,
   output logic [ENTRY_W-1:0]        m_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [LVL_W-1:0]          fifo_level,
   output logic                      overflow,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
`ifdef OUTPUT_SPIKE_COUNT_EN
   ,
   output logic [IDX_W:0]            last_tick_count
`endif
);

   entry_t                    wr_entry;
   logic                      push_ok, drop;
   logic [TS_W-1:0]           tick_stamp_q, tick_stamp_d;
   logic                      overflow_q, overflow_d;
   logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

   assign wr_entry = '{tick_stamp: tick_stamp_q, index: packet_in};
   assign drop     = packet_in_valid && !push_ok;

   spike_fifo u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (packet_in_valid),
      .wr_data  (wr_entry),
      .rd_ready (m_ready),
      .rd_data  (m_data),
      .rd_valid (m_valid),
      .push_ok  (push_ok),
      .level    (fifo_level)
   );

   // A spike arriving with tick still sees the pre-increment stamp_q.
   always_comb begin
      tick_stamp_d = tick_stamp_q;
      if (tick) begin
         tick_stamp_d = (tick_stamp_q == TS_W'(NUM_TICKS - 1)) ? '0 : tick_stamp_q + TS_W'(1);
      end
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      if (clear_status) begin
         overflow_d   = 1'b0;
         drop_count_d = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != DROP_CNT_MAX) drop_count_d = drop_count_q + DROP_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_stamp_q <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         tick_stamp_q <= tick_stamp_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

`ifdef OUTPUT_SPIKE_COUNT_EN
   localparam logic [IDX_W:0] CNT_MAX = '1;

   logic [IDX_W:0] cur_count_q, cur_count_d, cur_plus;
   logic [IDX_W:0] last_tick_count_q, last_tick_count_d;

   // The push landing on the tick cycle belongs to the tick that is closing.
   always_comb begin
      cur_plus = cur_count_q;
      if (push_ok && cur_count_q != CNT_MAX) cur_plus = cur_count_q + (IDX_W + 1)'(1);
      cur_count_d       = cur_plus;
      last_tick_count_d = last_tick_count_q;
      if (tick) begin
         last_tick_count_d = cur_plus;
         cur_count_d       = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_count_q       <= '0;
         last_tick_count_q <= '0;
      end else begin
         cur_count_q       <= cur_count_d;
         last_tick_count_q <= last_tick_count_d;
      end
   end

   assign last_tick_count = last_tick_count_q;
`endif

endmodule

// File: tb/tb_output_spike_collector.sv
// Directed bench for output_spike_collector: queue-based reference model compared
// every cycle, plus hand-computed expectations at key points.
module tb_output_spike_collector;

   localparam int DEPTH    = 64;
   localparam int TICKS    = 16;
   localparam int DROP_MAX = 65535;
   localparam int CNT_MAX  = 511;

   logic        clk;
   logic        rst;
   logic [7:0]  packet_in;
   logic        packet_in_valid;
   logic        tick;
   logic        clear_status;
   logic [11:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic [6:0]  fifo_level;
   logic        overflow;
   logic [15:0] drop_count;
`ifdef OUTPUT_SPIKE_COUNT_EN
   logic [8:0]  last_tick_count;
`endif

   int checks = 0;
   int errors = 0;

   output_spike_collector dut (
      .clk             (clk),
      .rst             (rst),
      .packet_in       (packet_in),
      .packet_in_valid (packet_in_valid),
      .tick            (tick),
      .clear_status    (clear_status),
      .m_data          (m_data),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .fifo_level      (fifo_level),
      .overflow        (overflow),
      .drop_count      (drop_count)
`ifdef OUTPUT_SPIKE_COUNT_EN
      ,
      .last_tick_count (last_tick_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the FIFO is a queue of {stamp, index}; counters are plain ints.
   logic [11:0] mq[$];
   int          m_stamp;
   bit          m_ovf;
   int          m_drop;
   int          m_cur;
   int          m_last;

   always @(posedge clk or posedge rst) begin
      bit pop;
      bit acc;
      if (rst) begin
         mq.delete();
         m_stamp = 0;
         m_ovf   = 0;
         m_drop  = 0;
         m_cur   = 0;
         m_last  = 0;
      end else begin
         pop = (mq.size() > 0) && m_ready;
         acc = packet_in_valid && ((mq.size() < DEPTH) || pop);
         if (pop) void'(mq.pop_front());
         if (acc) mq.push_back({m_stamp[3:0], packet_in});
         if (clear_status) begin
            m_ovf  = 0;
            m_drop = 0;
         end else if (packet_in_valid && !acc) begin
            m_ovf = 1;
            if (m_drop < DROP_MAX) m_drop++;
         end
         if (acc && m_cur < CNT_MAX) m_cur++;
         if (tick) begin
            m_last  = m_cur;
            m_cur   = 0;
            m_stamp = (m_stamp + 1) % TICKS;
         end
      end
   end

   always @(negedge clk) begin
      check("m_valid", m_valid, mq.size() > 0);
      check("m_data", m_data, (mq.size() > 0) ? mq[0] : 12'h000);
      check("fifo_level", fifo_level, mq.size());
      check("overflow", overflow, m_ovf);
      check("drop_count", drop_count, m_drop);
`ifdef OUTPUT_SPIKE_COUNT_EN
      check("last_tick_count", last_tick_count, m_last);
`endif
   end

   task automatic cyc(input bit v, input logic [7:0] idx, input bit t, input bit c);
      packet_in_valid = v;
      packet_in       = idx;
      tick            = t;
      clear_status    = c;
      @(posedge clk);
      #1;
      packet_in_valid = 1'b0;
      tick            = 1'b0;
      clear_status    = 1'b0;
   endtask

   initial begin
      packet_in = '0; packet_in_valid = 0; tick = 0; clear_status = 0; m_ready = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("lit_reset_valid", m_valid, 0);
      check("lit_reset_data", m_data, 0);
      check("lit_reset_level", fifo_level, 0);
      check("lit_reset_drop", drop_count, 0);
      rst = 1'b0;

      // Three pushes with the consumer stalled.
      cyc(1, 8'd5, 0, 0);
      check("lit_first_valid", m_valid, 1);
      check("lit_first_data", m_data, 12'h005);
      cyc(1, 8'd6, 0, 0);
      cyc(1, 8'd7, 0, 0);
      check("lit_hold_data", m_data, 12'h005);
      check("lit_level3", fifo_level, 3);

      // Drain on consecutive cycles.
      m_ready = 1;
      cyc(0, 0, 0, 0);
      check("lit_drain_6", m_data, 12'h006);
      cyc(0, 0, 0, 0);
      check("lit_drain_7", m_data, 12'h007);
      cyc(0, 0, 0, 0);
      check("lit_drained_valid", m_valid, 0);
      check("lit_drained_level", fifo_level, 0);
      m_ready = 0;

      // Tick coincident with a push keeps the old stamp.
      cyc(1, 8'd9, 1, 0);
      cyc(1, 8'd10, 0, 0);
      check("lit_tick_push_old", m_data, 12'h009);
      m_ready = 1;
      cyc(0, 0, 0, 0);
      check("lit_tick_push_new", m_data, 12'h10A);
      cyc(0, 0, 0, 0);
      m_ready = 0;

      // Stamp is 1; 14 ticks reach 15, one more wraps to 0.
      repeat (14) cyc(0, 0, 1, 0);
      cyc(1, 8'h22, 0, 0);
      check("lit_stamp15", m_data, 12'hF22);
      m_ready = 1;
      cyc(0, 0, 1, 0);
      m_ready = 0;
      cyc(1, 8'h23, 0, 0);
      check("lit_stamp_wrap", m_data, 12'h023);
      m_ready = 1;
      cyc(0, 0, 0, 0);
      m_ready = 0;

      // Fill, then overflow by three.
      for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
      check("lit_full_level", fifo_level, 64);
      repeat (3) cyc(1, 8'hEE, 0, 0);
      check("lit_drop3", drop_count, 3);
      check("lit_ovf", overflow, 1);
      check("lit_full_level2", fifo_level, 64);

      // Push while full and popping: accepted.
      m_ready = 1;
      cyc(1, 8'hAA, 0, 0);
      m_ready = 0;
      check("lit_fullpop_drop", drop_count, 3);
      check("lit_fullpop_level", fifo_level, 64);
      check("lit_fullpop_head", m_data, 12'h001);

      // Clear wins over a coincident drop.
      cyc(1, 8'hBB, 0, 1);
      check("lit_clear_ovf", overflow, 0);
      check("lit_clear_drop", drop_count, 0);

      // Saturate the drop counter.
      repeat (DROP_MAX) cyc(1, 8'hCC, 0, 0);
      check("lit_drop_max", drop_count, 16'hFFFF);
      cyc(1, 8'hCC, 0, 0);
      check("lit_drop_sat", drop_count, 16'hFFFF);

      // Drain to level 10, then reset asynchronously.
      m_ready = 1;
      repeat (54) cyc(0, 0, 0, 0);
      check("lit_level10", fifo_level, 10);
      rst = 1'b1;
      #2;
      check("lit_async_valid", m_valid, 0);
      check("lit_async_data", m_data, 0);
      check("lit_async_level", fifo_level, 0);
      check("lit_async_ovf", overflow, 0);
      check("lit_async_drop", drop_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_ready = 0;

      cyc(1, 8'd1, 0, 0);
      check("lit_after_reset", m_data, 12'h001);

`ifdef OUTPUT_SPIKE_COUNT_EN
      m_ready = 1;
      cyc(0, 0, 1, 0);
      check("lit_count_1", last_tick_count, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'(i + 40), 0, 0);
      cyc(1, 8'd50, 1, 0);
      check("lit_count_5", last_tick_count, 5);
      cyc(0, 0, 1, 0);
      check("lit_count_0", last_tick_count, 0);
      m_ready = 0;
`endif

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/output_spike_collector.md
Name: output_spike_collector

Overview:
- Sits directly downstream of the grid's output bus.
- Captures every output-spike index the bus emits (valid pulse, no backpressure available) and tags it with the current tick stamp.
- Buffers the tagged spikes in a FIFO and drains them to the host-side consumer through a valid/ready stream.
- Reports overflow and drop statistics, because the upstream cannot be stalled.

Parameters:
- NUM_OUTPUTS, 256, number of distinct output indices; index width IDX_W = $clog2(NUM_OUTPUTS).
- NUM_TICKS, 16, tick-stamp modulus; stamp width TS_W = $clog2(NUM_TICKS).
- FIFO_DEPTH, 64, number of entries; must be a power of two, ≥2.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- packet_in  in  IDX_W  output-spike index from the output bus
- packet_in_valid  in  1  single-cycle qualifier for packet_in
- tick  in  1  single-cycle pulse marking the end of the current tick
- clear_status  in  1  clears overflow and drop_count
- m_data  out  TS_W+IDX_W  {tick_stamp, index}
- m_valid  out  1  m_data holds a valid entry
- m_ready  in  1  consumer accepts m_data when m_valid is high
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky flag: at least one spike was dropped
- drop_count  out  DROP_CNT_WIDTH  number of dropped spikes, saturating

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, fifo_level=0, overflow=0, drop_count=0, tick_stamp=0, read/write pointers=0.
- Push: on packet_in_valid, write {tick_stamp, packet_in}.
- Accept condition: push is accepted if level<FIFO_DEPTH, or if level==FIFO_DEPTH and a pop occurs in the same cycle.
- Otherwise the spike is dropped: overflow<=1 and drop_count increments, saturating at all-ones.
- Pop: occurs when m_valid && m_ready.
- m_data/m_valid follow show-ahead semantics: m_data is the head entry whenever m_valid=1.
- m_data and m_valid must not change while m_valid=1 && m_ready=0.
- Latency: a push into an empty FIFO gives m_valid=1 on the next cycle. Combinational input-to-output bypass is forbidden.
- Simultaneous push and pop with level=0: push is written, the pop cannot occur (m_valid=0), and level becomes 1.
- Simultaneous push and pop with 0<level<FIFO_DEPTH: level is unchanged.
- Tick: tick_stamp <= (tick_stamp+1) mod NUM_TICKS. Wraps from NUM_TICKS-1 to 0.
- Tick and packet_in_valid in the same cycle: the packet takes the pre-increment stamp.
- clear_status: overflow<=0 and drop_count<=0 next cycle.
- clear_status coincident with a drop: clear wins, both read 0 next cycle, and that drop is not counted.
- clear_status has no effect on FIFO contents or tick_stamp.
- Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. fifo_level is a registered counter, not derived from the pointers.
- There are no other states. The block is a pure FIFO controller plus status registers.

Optional Feature:
- Macro: OUTPUT_SPIKE_COUNT_EN.
- When defined, the block adds output last_tick_count [IDX_W:0] and an internal counter cur_count.
- cur_count increments on every accepted push and excludes drops.
- On tick, last_tick_count <= cur_count, including any push accepted in that same cycle. cur_count then restarts at 0.
- Both counters saturate, and both reset to 0.
- When undefined, the port and logic are absent and the behaviour above is unchanged.

Decomposition:
- Package ranc_output_pkg holds:
  - function to compute IDX_W/TS_W from parameters
  - entry struct/typedef {tick_stamp, index}
  - constant for the drop-counter saturation value
- One natural sub-module: spike_fifo (synchronous show-ahead FIFO with registered level, full/empty flags, simultaneous push/pop when full).
- Tick stamping, drop accounting and the optional counter stay in the top module.

Test Plan:
- Reset, then push indices 5,6,7 with tick_stamp 0 and m_ready=0 -> m_valid=1 one cycle after the first push, m_data={0,5} held stable, fifo_level=3.
- Raise m_ready -> {0,5}, {0,6}, {0,7} are popped on consecutive cycles, then m_valid=0 and fifo_level=0.
- tick together with push of index 9, then push index 10 -> entries read {0,9} then {1,10}.
- Issue 16 ticks -> stamp wraps back to 0.
- Fill to 64 with m_ready=0, then 3 more pushes -> 3 drops, overflow=1, drop_count=3, fifo_level=64.
- Push while full and popping in the same cycle -> accepted, drop_count unchanged.
- clear_status coincident with a drop -> overflow=0, drop_count=0.
- Force drop_count to all-ones, then drop -> drop_count stays 0xFFFF.
- Assert rst mid-drain with level=10 -> all outputs 0 immediately without waiting for a clock.
- After release, push index 1 -> m_data={0,1}.
- OUTPUT_SPIKE_COUNT_EN: 4 pushes, then tick coincident with a 5th push -> last_tick_count=5, next tick with no pushes -> 0.
